seg_to_num: RTL

SEG_TO_NUM -- requirements
Module: seg_to_num

---
 rtl/seg_to_num.sv | 98 +++++++++
 1 files changed

// File: rtl/seg_to_num.sv
// Seven-segment digit stream to binary: four active-low digits per frame,
// thousands first, decoded and accumulated into a 14-bit value.
module seg_to_num (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic        seg_sof,
  input  logic        seg_valid,
  output logic        seg_ready,
  output logic [13:0] num,
  output logic        num_valid,
  output logic        err
);

  typedef enum logic {
    COLLECT,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [13:0] acc;
  logic        ferr;

  logic [3:0]  digit;
  logic        illegal;
  logic        take;
  logic        first;
  logic        last;
  logic [13:0] base;
  logic [13:0] acc_next;
  logic        ferr_next;

  always_comb begin
    digit   = 4'd0;
    illegal = 1'b0;
    case (seg_in)
      7'b0000001: digit = 4'd0;
      7'b1001111: digit = 4'd1;
      7'b0010010: digit = 4'd2;
      7'b0000110: digit = 4'd3;
      7'b1001100: digit = 4'd4;
      7'b0100100: digit = 4'd5;
      7'b0100000: digit = 4'd6;
      7'b0001111: digit = 4'd7;
      7'b0000000: digit = 4'd8;
      7'b0000100: digit = 4'd9;
      default:    illegal = 1'b1;
    endcase
  end

  assign seg_ready = (state == COLLECT);
  assign take      = seg_valid && seg_ready;

  // A sof mid-frame restarts the frame; a missing sof on digit 0 is a fault.
  assign first     = (idx == 2'd0) || seg_sof;
  assign base      = first ? 14'd0 : acc;
  assign acc_next  = (base << 3) + (base << 1) + {10'd0, digit};
  assign ferr_next = (first ? ~seg_sof : ferr) | illegal;
  assign last      = !first && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= 2'd0;
      acc       <= 14'd0;
      ferr      <= 1'b0;
      num       <= 14'd0;
      err       <= 1'b0;
      num_valid <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (take) begin
            acc  <= acc_next;
            ferr <= ferr_next;
            if (last) begin
              state     <= DONE;
              idx       <= 2'd0;
              num_valid <= 1'b1;
              num       <= ferr_next ? 14'd0 : acc_next;
              err       <= ferr_next;
            end else begin
              idx <= first ? 2'd1 : idx + 2'd1;
            end
          end
        end
        DONE: begin
          state <= COLLECT;
          idx   <= 2'd0;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
